axi_sram_slave: RTL and testbench

//  AXI responder backed by an on-chip word array. Used as the memory-side model and test target
//  for the cache-side AXI master. Serves INCR/FIXED/WRAP bursts with byte strobes.

---
 rtl/axi_sram_slave_if.sv | 54 +++++
 rtl/axi_sram_slave.sv | 208 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave_if : AR/R/AW/W/B channel bundle for axi_sram_slave          |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave : AXI responder over a 32-bit word array, INCR/FIXED/WRAP   |
// | Optional out-of-window DECERR decode: define AXI_SLV_DECERR_EN            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             resetn,
  axi_sram_slave_if.slave  s_axi
);

  logic [31:0] mem_q [2**MEM_AW];

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] bound;
    incr  = 32'd1 << ((size > 3'd2) ? 2'd2 : size[1:0]);
    bound = ({24'd0, len} + 32'd1) * incr;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~(bound - 32'd1)) | ((a + incr) & (bound - 32'd1));
      default: next_addr = a + incr;
    endcase
  endfunction

  logic w_ar_oor;
  logic w_aw_oor;
`ifdef AXI_SLV_DECERR_EN
  assign w_ar_oor = (s_axi.araddr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
  assign w_aw_oor = (s_axi.awaddr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]);
`else
  assign w_ar_oor = 1'b0;
  assign w_aw_oor = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^s_axi.wid;

  // ---------------- read channel ----------------
  typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_e;
  rstate_e     rstate_q;
  logic        arready_q, rvalid_q, rlast_q, roor_q;
  logic [31:0] rdata_q, raddr_q, raddr_d, w_ar_next;
  logic [1:0]  rresp_q, rburst_q;
  logic [3:0]  rid_q;
  logic [7:0]  rlen_q, rbeat_q;
  logic [2:0]  rsize_q;
  logic [MEM_AW-1:0] w_ar_idx, w_ridx;

  // raddr_q always holds the address of the next beat to be loaded
  assign raddr_d   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
  assign w_ar_next = next_addr(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
  assign w_ar_idx  = s_axi.araddr[MEM_AW+1:2];
  assign w_ridx    = raddr_q[MEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      roor_q    <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi.arvalid && arready_q) begin
            arready_q <= 1'b0;
            rlen_q    <= s_axi.arlen;
            rsize_q   <= s_axi.arsize;
            rburst_q  <= s_axi.arburst;
            roor_q    <= w_ar_oor;
            raddr_q   <= w_ar_next;
            rbeat_q   <= '0;
            rid_q     <= s_axi.arid;
            rvalid_q  <= 1'b1;
            rlast_q   <= (s_axi.arlen == 8'd0);
            rdata_q   <= w_ar_oor ? 32'd0 : mem_q[w_ar_idx];
            rresp_q   <= w_ar_oor ? 2'b11 : 2'b00;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_q && s_axi.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              rbeat_q <= rbeat_q + 8'd1;
              rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
              rdata_q <= roor_q ? 32'd0 : mem_q[w_ridx];
              raddr_q <= raddr_d;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  wstate_e     wstate_q;
  logic        awready_q, wready_q, bvalid_q, woor_q, w_we;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q;
  logic [2:0]  wsize_q;
  logic [1:0]  wburst_q, bresp_q;
  logic [3:0]  awid_q, bid_q;
  logic [MEM_AW-1:0] w_widx;

  assign waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
  assign w_widx  = waddr_q[MEM_AW+1:2];
  assign w_we    = resetn && wready_q && s_axi.wvalid && !woor_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      awid_q    <= '0;
      woor_q    <= 1'b0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            waddr_q   <= s_axi.awaddr;
            wlen_q    <= s_axi.awlen;
            wsize_q   <= s_axi.awsize;
            wburst_q  <= s_axi.awburst;
            awid_q    <= s_axi.awid;
            woor_q    <= w_aw_oor;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          // wlast alone closes the burst; surplus beats keep advancing the address
          if (s_axi.wvalid && wready_q) begin
            waddr_q <= waddr_d;
            if (s_axi.wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= awid_q;
              bresp_q  <= woor_q ? 2'b11 : 2'b00;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid_q && s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi.wstrb[i]) mem_q[w_widx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_sram_slave : table vectors plus burst sequences for axi_sram_slave  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_axi_sram_slave;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .MEM_AW   (14),
    .BASE_ADDR(32'h0000_0000),
    .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .s_axi (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;
  rbeat_t exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;
  vec_t vt [10];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    rbeat_t e;
    e.data = d; e.resp = r; e.last = l; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int cyc;
    int got;
    rbeat_t e;
    logic [31:0] hold_d;
    bit holding;
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    cyc = 0;
    while (bus.arready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) begin
      chk("ar_handshake_timeout", 32'd0, 32'd1);
      bus.arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("r_first_latency", {31'd0, bus.rvalid}, 32'd1);
    got = 0; cyc = 0; holding = 0; hold_d = '0;
    while (got <= int'(len) && cyc < 200) begin
      bus.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (bus.rvalid === 1'b1) begin
        if (holding) chk("r_stable", bus.rdata, hold_d);
        if (bus.rready) begin
          holding = 0;
          got++;
          if (exp_q.size() == 0) begin
            chk("r_unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", bus.rdata, e.data);
            chk("rresp", {30'd0, bus.rresp}, {30'd0, e.resp});
            chk("rlast", {31'd0, bus.rlast}, {31'd0, e.last});
            chk("rid", {28'd0, bus.rid}, {28'd0, e.id});
          end
        end else begin
          holding = 1;
          hold_d = bus.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (got <= int'(len)) chk("r_beat_timeout", got, {24'd0, len} + 32'd1);
    chk("r_idle_after_last", {31'd0, bus.rvalid}, 32'd0);
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [31:0] d [16], input logic [3:0] s [16], input logic [1:0] exp_bresp);
    int cyc;
    int b;
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    cyc = 0;
    while (bus.awready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) begin
      chk("aw_handshake_timeout", 32'd0, 32'd1);
      bus.awvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    b = 0; cyc = 0;
    while (b < nbeats && cyc < 100) begin
      bus.wvalid = 1'b1;
      bus.wdata  = d[b];
      bus.wstrb  = s[b];
      bus.wlast  = (b == nbeats - 1);
      if (bus.wready === 1'b1) b++;
      @(negedge clk);
      cyc++;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    if (b < nbeats) chk("w_beat_timeout", b, nbeats);
    bus.bready = 1'b1;
    cyc = 0;
    while (bus.bvalid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) begin
      chk("b_timeout", 32'd0, 32'd1);
    end else begin
      chk("bresp", {30'd0, bus.bresp}, {30'd0, exp_bresp});
      chk("bid", {28'd0, bus.bid}, {28'd0, id});
    end
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input logic [1:0] exp_bresp);
    logic [31:0] d [16];
    logic [3:0]  s [16];
    for (int i = 0; i < 16; i++) begin d[i] = '0; s[i] = '0; end
    d[0] = data; s[0] = strb;
    wr_burst(4'h3, addr, 8'd0, 3'd2, 2'b01, 1, d, s, exp_bresp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    // reset held three cycles, every output low throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_ctrl", {26'd0, bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast}, 32'd0);
      chk("reset_data", bus.rdata | {24'd0, bus.rid, bus.bid} | {28'd0, bus.rresp, bus.bresp}, 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("arready_after_reset", {31'd0, bus.arready}, 32'd1);
    chk("awready_after_reset", {31'd0, bus.awready}, 32'd1);

    vt[0] = '{1'b1, 32'h100, 32'h1122_3344, 4'hF};
    vt[1] = '{1'b1, 32'h100, 32'hAABB_CCDD, 4'b0010};
    vt[2] = '{1'b0, 32'h100, 32'h1122_CC44, 4'h0};
    vt[3] = '{1'b1, 32'h104, 32'h0102_0304, 4'hF};
    vt[4] = '{1'b1, 32'h104, 32'hFFEE_DDCC, 4'b1001};
    vt[5] = '{1'b0, 32'h104, 32'hFF02_03CC, 4'h0};
    vt[6] = '{1'b1, 32'h10C, 32'h0000_FFFF, 4'hF};
    vt[7] = '{1'b1, 32'h10C, 32'h1234_5678, 4'b0110};
    vt[8] = '{1'b0, 32'h10C, 32'h0034_56FF, 4'h0};
    vt[9] = '{1'b0, 32'h100, 32'h1122_CC44, 4'h0};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        wr1(vt[i].addr, vt[i].data, vt[i].strb, 2'b00);
      end else begin
        push_exp(vt[i].data, 2'b00, 1'b1, 4'h5);
        rd_burst(4'h5, vt[i].addr, 8'd0, 3'd2, 2'b01, 1'b0);
      end
    end

    // INCR burst write 1..4, read back with rready toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    wr_burst(4'hA, 32'h200, 8'd3, 3'd2, 2'b01, 4, wd, ws, 2'b00);
    for (int i = 0; i < 4; i++) push_exp(32'(i + 1), 2'b00, i == 3, 4'h7);
    rd_burst(4'h7, 32'h200, 8'd3, 3'd2, 2'b01, 1'b1);

    // WRAP len=3 from 0x208 visits 0x208,0x20C,0x200,0x204
    push_exp(32'd3, 2'b00, 1'b0, 4'h2);
    push_exp(32'd4, 2'b00, 1'b0, 4'h2);
    push_exp(32'd1, 2'b00, 1'b0, 4'h2);
    push_exp(32'd2, 2'b00, 1'b1, 4'h2);
    rd_burst(4'h2, 32'h208, 8'd3, 3'd2, 2'b10, 1'b0);

    // WRAP len=1 from 0x204 wraps to 0x200
    push_exp(32'd2, 2'b00, 1'b0, 4'h4);
    push_exp(32'd1, 2'b00, 1'b1, 4'h4);
    rd_burst(4'h4, 32'h204, 8'd1, 3'd2, 2'b10, 1'b0);

    // byte-sized INCR: four beats over 0x201..0x204, full words returned
    push_exp(32'd1, 2'b00, 1'b0, 4'h1);
    push_exp(32'd1, 2'b00, 1'b0, 4'h1);
    push_exp(32'd1, 2'b00, 1'b0, 4'h1);
    push_exp(32'd2, 2'b00, 1'b1, 4'h1);
    rd_burst(4'h1, 32'h201, 8'd3, 3'd0, 2'b01, 1'b0);

    // reserved burst type advances like INCR
    push_exp(32'd1, 2'b00, 1'b0, 4'h9);
    push_exp(32'd2, 2'b00, 1'b1, 4'h9);
    rd_burst(4'h9, 32'h200, 8'd1, 3'd2, 2'b11, 1'b0);

    // FIXED write: every beat lands on the same word
    wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hB1B1_B1B1; wd[2] = 32'hC2C2_C2C2;
    wr_burst(4'hB, 32'h400, 8'd2, 3'd2, 2'b00, 3, wd, ws, 2'b00);
    push_exp(32'hC2C2_C2C2, 2'b00, 1'b0, 4'h6);
    push_exp(32'hC2C2_C2C2, 2'b00, 1'b1, 4'h6);
    rd_burst(4'h6, 32'h400, 8'd1, 3'd2, 2'b00, 1'b0);

    // len=0 but wlast only on beat 2: both beats written
    wd[0] = 32'h0000_0077; wd[1] = 32'h0000_0088;
    wr_burst(4'hC, 32'h500, 8'd0, 3'd2, 2'b01, 2, wd, ws, 2'b00);
    push_exp(32'h0000_0077, 2'b00, 1'b0, 4'h8);
    push_exp(32'h0000_0088, 2'b00, 1'b1, 4'h8);
    rd_burst(4'h8, 32'h500, 8'd1, 3'd2, 2'b01, 1'b0);

    // concurrent AR/AW to one word: read sees the old value
    wr1(32'h300, 32'd5, 4'hF, 2'b00);
    wd[0] = 32'd9;
    push_exp(32'd5, 2'b00, 1'b1, 4'hE);
    fork
      rd_burst(4'hE, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0);
      wr_burst(4'hD, 32'h300, 8'd0, 3'd2, 2'b01, 1, wd, ws, 2'b00);
    join
    push_exp(32'd9, 2'b00, 1'b1, 4'hE);
    rd_burst(4'hE, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0);

`ifdef AXI_SLV_DECERR_EN
    wr1(32'h0, 32'h1234_5678, 4'hF, 2'b00);
    push_exp(32'd0, 2'b11, 1'b0, 4'hF);
    push_exp(32'd0, 2'b11, 1'b1, 4'hF);
    rd_burst(4'hF, 32'h0001_0000, 8'd1, 3'd2, 2'b01, 1'b0);
    wr1(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 2'b11);
    push_exp(32'h1234_5678, 2'b00, 1'b1, 4'hF);
    rd_burst(4'hF, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);
`else
    // upper address bits alias into the array
    wr1(32'h0004_0110, 32'hCAFE_F00D, 4'hF, 2'b00);
    push_exp(32'hCAFE_F00D, 2'b00, 1'b1, 4'h5);
    rd_burst(4'h5, 32'h110, 8'd0, 3'd2, 2'b01, 1'b0);
`endif

    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
